// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types and constants for the core pipeline.
//   fetch_state_t : fetch FSM states (IDLE / WAIT / KILL)
//   NOP_INSTR     : canonical bubble instruction (addi x0, x0, 0)
//   fetch_pkt_t   : {instr, pc} pair moved between memory, skid and IF/ID
//   next_pc()     : sequential PC increment, wraps modulo 2^32
package pipeline_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,   // nothing outstanding
      WAIT = 2'd1,   // one live request outstanding
      KILL = 2'd2    // one outstanding request whose response is discarded
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_pkt_t;

   function automatic logic [31:0] next_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry buffer holding a fetched packet while decode stalls.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : drop any held entry (highest priority)
//   push     : write din; a simultaneous pop is a replace, entry stays full
//   pop      : release the held entry
//   din/dout : packet in / held packet out
//   full     : an entry is held
module fetch_skid_buf
   import pipeline_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       push,
   input  logic       pop,
   input  fetch_pkt_t din,
   output fetch_pkt_t dout,
   output logic       full
);

   fetch_pkt_t data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data <= '0;
         full <= 1'b0;
      end else if (clear) begin
         full <= 1'b0;
      end else if (push) begin
         data <= din;
         full <= 1'b1;
      end else if (pop) begin
         full <= 1'b0;
      end
   end

   assign dout = data;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns the PC, issues at most one
// outstanding instruction-memory request, discards wrong-path responses and
// fills the IF/ID register through a one-entry skid buffer.
//   clk, rst            : clock, asynchronous active-high reset
//   stall_f, stall_d    : hold PC / hold IF/ID
//   flush_d             : invalidate IF/ID and skid buffer
//   pc_src_e, pc_target_e : redirect from execute
//   imem_req/addr/gnt   : request handshake (addr always equals pc_f)
//   imem_rvalid/rdata   : response
//   pc_f                : current fetch PC
//   valid_d, instr_d, pc_d, pc_plus4_d : IF/ID register contents
module fetch_stage
   import pipeline_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_f,
   input  logic        stall_d,
   input  logic        flush_d,
   input  logic        pc_src_e,
   input  logic [31:0] pc_target_e,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_f,
   output logic        valid_d,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc_plus4_d
);

   fetch_state_t state;
   logic [31:0]  inflight_pc;

   logic         skid_full;
   fetch_pkt_t   skid_dout;
   logic         skid_push;
   logic         skid_pop;
   logic         skid_clear;

   logic         busy;       // a request is outstanding (live or killed)
   logic         fire;       // request accepted this cycle
   logic         deliver;    // live response to forward this cycle
   logic         kill;       // IF/ID and skid are invalidated this cycle

   assign busy = (state == WAIT) || (state == KILL);

   // A response slot frees up the cycle rvalid arrives, so a new request may
   // go out alongside it; this also covers the stale response in KILL, which
   // lets the redirect target be requested in that same cycle.
   assign imem_req = !rst && !stall_f && !pc_src_e && !skid_full &&
                     ((state == IDLE) || (busy && imem_rvalid));
   assign imem_addr = pc_f;

   assign fire    = imem_req && imem_gnt;
   assign deliver = (state == WAIT) && imem_rvalid && !pc_src_e && !flush_d;
   assign kill    = pc_src_e || flush_d;

   // With decode moving and the skid full, the skid drains into IF/ID and a
   // same-cycle response takes its place (push wins over pop in the buffer).
   assign skid_clear = kill;
   assign skid_push  = deliver && (stall_d || skid_full);
   assign skid_pop   = !stall_d && skid_full;

   fetch_skid_buf u_skid (
      .clk   (clk),
      .rst   (rst),
      .clear (skid_clear),
      .push  (skid_push),
      .pop   (skid_pop),
      .din   ('{instr: imem_rdata, pc: inflight_pc}),
      .dout  (skid_dout),
      .full  (skid_full)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         pc_f        <= RESET_PC;
         inflight_pc <= '0;
         valid_d     <= 1'b0;
         instr_d     <= NOP_INSTR;
         pc_d        <= '0;
      end else begin
         if (fire) begin
            inflight_pc <= pc_f;
         end

         if (pc_src_e) begin
            pc_f <= pc_target_e;
         end else if (fire) begin
            pc_f <= next_pc(pc_f);
         end

         case (state)
            IDLE: state <= fire ? WAIT : IDLE;
            WAIT: begin
               if (imem_rvalid) begin
                  state <= fire ? WAIT : IDLE;
               end else if (pc_src_e) begin
                  state <= KILL;
               end
            end
            KILL: begin
               if (imem_rvalid) begin
                  state <= fire ? WAIT : IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (kill) begin
            valid_d <= 1'b0;
            instr_d <= NOP_INSTR;
         end else if (!stall_d) begin
            if (skid_full) begin
               valid_d <= 1'b1;
               instr_d <= skid_dout.instr;
               pc_d    <= skid_dout.pc;
            end else if (deliver) begin
               valid_d <= 1'b1;
               instr_d <= imem_rdata;
               pc_d    <= inflight_pc;
            end else begin
               valid_d <= 1'b0;
               instr_d <= NOP_INSTR;
            end
         end
      end
   end

   assign pc_plus4_d = pc_d + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: self-checking bench for fetch_stage (RESET_PC = 0x100).
// Directed table, hand-written redirect/reset sequences, then randomized
// traffic against a transaction-level reference model.
module tb_fetch_stage;
   import pipeline_pkg::*;

   localparam logic [31:0] RPC = 32'h0000_0100;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_f = 1'b0, stall_d = 1'b0, flush_d = 1'b0, pc_src_e = 1'b0;
   logic [31:0] pc_target_e = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] pc_f;
   logic        valid_d;
   logic [31:0] instr_d, pc_d, pc_plus4_d;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   fetch_stage #(.RESET_PC(RPC)) dut (
      .clk         (clk),
      .rst         (rst),
      .stall_f     (stall_f),
      .stall_d     (stall_d),
      .flush_d     (flush_d),
      .pc_src_e    (pc_src_e),
      .pc_target_e (pc_target_e),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .pc_f        (pc_f),
      .valid_d     (valid_d),
      .instr_d     (instr_d),
      .pc_d        (pc_d),
      .pc_plus4_d  (pc_plus4_d)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        sf, sd, fl, ps;
      logic [31:0] tgt;
      logic        g, rv;
      logic [31:0] rd;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_instr;
      logic [31:0] e_pcd;
   } vec_t;

   vec_t tbl[15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   // Apply one cycle of inputs at the falling edge; outputs settle by #1.
   task automatic drive(input logic sf, input logic sd, input logic fl, input logic ps,
                        input logic [31:0] tgt, input logic g, input logic rv,
                        input logic [31:0] rd);
      @(negedge clk);
      rst = 1'b0;
      stall_f = sf; stall_d = sd; flush_d = fl; pc_src_e = ps;
      pc_target_e = tgt; imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 0;
      pc_target_e = '0; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
      #1;
      check("rst_req", {31'd0, imem_req}, 32'd0);
      tick();
      check("rst_req_post", {31'd0, imem_req}, 32'd0);
      check("rst_pc_f", pc_f, RPC);
      check("rst_valid", {31'd0, valid_d}, 32'd0);
      check("rst_instr", instr_d, NOP);
      check("rst_pc_d", pc_d, 32'd0);
      check("rst_pc_plus4", pc_plus4_d, 32'd4);
   endtask

   // Reference model state (transaction level).
   logic        m_out, m_wrong;
   logic [31:0] m_pc, m_opc;
   logic        m_valid;
   logic [31:0] m_instr, m_pcd;
   fetch_pkt_t  skidq[$];
   int unsigned mem_cnt;

   initial begin
      //            sf sd fl ps tgt          g  rv rd             req addr         vld instr          pc_d
      tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,   1'b1,1'b0,32'h0,         1'b1,32'h100,1'b0,NOP,           32'h0};
      tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,   1'b1,1'b1,32'hC0DE_0000, 1'b1,32'h104,1'b1,32'hC0DE_0000, 32'h100};
      tbl[2]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,   1'b1,1'b1,32'hC0DE_0001, 1'b1,32'h108,1'b1,32'hC0DE_0001, 32'h104};
      tbl[3]  = '{1'b1,1'b1,1'b0,1'b0,32'h0,   1'b1,1'b1,32'hC0DE_0002, 1'b0,32'h10C,1'b1,32'hC0DE_0001, 32'h104};
      tbl[4]  = '{1'b1,1'b1,1'b0,1'b0,32'h0,   1'b1,1'b0,32'h0,         1'b0,32'h10C,1'b1,32'hC0DE_0001, 32'h104};
      tbl[5]  = '{1'b1,1'b1,1'b0,1'b0,32'h0,   1'b1,1'b0,32'h0,         1'b0,32'h10C,1'b1,32'hC0DE_0001, 32'h104};
      tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,   1'b1,1'b0,32'h0,         1'b0,32'h10C,1'b1,32'hC0DE_0002, 32'h108};
      tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,   1'b1,1'b0,32'h0,         1'b1,32'h10C,1'b0,NOP,           32'h108};
      tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,   1'b0,1'b1,32'hC0DE_0003, 1'b1,32'h110,1'b1,32'hC0DE_0003, 32'h10C};
      tbl[9]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,   1'b1,1'b0,32'h0,         1'b1,32'h110,1'b0,NOP,           32'h10C};
      tbl[10] = '{1'b0,1'b0,1'b1,1'b0,32'h0,   1'b0,1'b1,32'hC0DE_0004, 1'b1,32'h114,1'b0,NOP,           32'h10C};
      tbl[11] = '{1'b0,1'b0,1'b0,1'b0,32'h0,   1'b1,1'b0,32'h0,         1'b1,32'h114,1'b0,NOP,           32'h10C};
      tbl[12] = '{1'b0,1'b0,1'b1,1'b1,32'h200, 1'b1,1'b1,32'hC0DE_0005, 1'b0,32'h118,1'b0,NOP,           32'h10C};
      tbl[13] = '{1'b0,1'b0,1'b0,1'b0,32'h0,   1'b1,1'b0,32'h0,         1'b1,32'h200,1'b0,NOP,           32'h10C};
      tbl[14] = '{1'b0,1'b0,1'b0,1'b0,32'h0,   1'b0,1'b1,32'hC0DE_0006, 1'b1,32'h204,1'b1,32'hC0DE_0006, 32'h200};

      // Directed table: startup, skid under stall, flush, redirect+flush.
      do_reset();
      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].sf, tbl[i].sd, tbl[i].fl, tbl[i].ps, tbl[i].tgt,
               tbl[i].g, tbl[i].rv, tbl[i].rd);
         check($sformatf("t%0d_req", i), {31'd0, imem_req}, {31'd0, tbl[i].e_req});
         check($sformatf("t%0d_addr", i), imem_addr, tbl[i].e_addr);
         check($sformatf("t%0d_pc_f", i), pc_f, tbl[i].e_addr);
         tick();
         check($sformatf("t%0d_valid", i), {31'd0, valid_d}, {31'd0, tbl[i].e_valid});
         check($sformatf("t%0d_instr", i), instr_d, tbl[i].e_instr);
         check($sformatf("t%0d_pc_d", i), pc_d, tbl[i].e_pcd);
         check($sformatf("t%0d_pc4", i), pc_plus4_d, tbl[i].e_pcd + 32'd4);
      end

      // Redirect while 0x10C is outstanding on a 3-cycle memory.
      do_reset();
      drive(0,0,0,0,32'h0,1,0,32'h0);          check("br_a0", imem_addr, 32'h100); tick();
      drive(0,0,0,0,32'h0,1,1,32'hA000_0000);  check("br_a1", imem_addr, 32'h104); tick();
      drive(0,0,0,0,32'h0,1,1,32'hA000_0004);  check("br_a2", imem_addr, 32'h108); tick();
      drive(0,0,0,0,32'h0,1,1,32'hA000_0008);  check("br_a3", imem_addr, 32'h10C); tick();
      check("br_pcd_108", pc_d, 32'h108);
      drive(0,0,0,1,32'h200,1,0,32'h0);
      check("br_req_redirect", {31'd0, imem_req}, 32'd0);
      tick();
      check("br_pc_target", pc_f, 32'h200);
      check("br_valid_inv", {31'd0, valid_d}, 32'd0);
      drive(0,0,0,0,32'h0,1,0,32'h0);
      check("br_req_kill", {31'd0, imem_req}, 32'd0);
      tick();
      drive(0,0,0,0,32'h0,1,1,32'hDEAD_010C);
      check("br_req_stale", {31'd0, imem_req}, 32'd1);
      check("br_addr_stale", imem_addr, 32'h200);
      tick();
      check("br_drop_valid", {31'd0, valid_d}, 32'd0);
      drive(0,0,0,0,32'h0,0,1,32'hBEEF_0200);
      check("br_addr_next", imem_addr, 32'h204);
      tick();
      check("br_valid", {31'd0, valid_d}, 32'd1);
      check("br_instr", instr_d, 32'hBEEF_0200);
      check("br_pcd", pc_d, 32'h200);

      // Reset asserted while in KILL; stray rvalid afterwards is ignored.
      do_reset();
      drive(0,0,0,0,32'h0,1,0,32'h0); tick();
      drive(0,0,0,1,32'h300,1,0,32'h0); tick();
      #2 rst = 1'b1;
      #1;
      check("rk_req_in_rst", {31'd0, imem_req}, 32'd0);
      check("rk_pc_in_rst", pc_f, RPC);
      drive(0,0,0,0,32'h0,0,1,32'h5555_5555);
      check("rk_req_stray", {31'd0, imem_req}, 32'd1);
      check("rk_addr_stray", imem_addr, RPC);
      tick();
      check("rk_valid_stray", {31'd0, valid_d}, 32'd0);
      check("rk_pc_hold", pc_f, RPC);
      drive(0,0,0,0,32'h0,1,0,32'h0);
      check("rk_addr_first", imem_addr, RPC);
      tick();
      check("rk_pc_adv", pc_f, RPC + 32'd4);

      // Randomized traffic against the reference model.
      do_reset();
      m_out = 0; m_wrong = 0; m_pc = RPC; m_opc = '0;
      m_valid = 0; m_instr = NOP; m_pcd = '0; skidq.delete(); mem_cnt = 0;
      for (int c = 0; c < 3000; c++) begin
         logic sf, sd, fl, ps, g, rv, e_req, fire, live;
         logic [31:0] tgt, rd;
         fetch_pkt_t pkt;
         @(negedge clk);
         sd  = ($urandom_range(0, 9) < 2);
         sf  = sd || ($urandom_range(0, 9) < 2);   // hazard unit never stalls D alone
         fl  = ($urandom_range(0, 19) == 0);
         ps  = ($urandom_range(0, 19) == 0);
         tgt = $urandom();
         tgt[1:0] = 2'b00;
         if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF8;
         g   = ($urandom_range(0, 9) < 7);
         rd  = $urandom();
         rv  = 1'b0;
         if (m_out) begin
            mem_cnt--;
            rv = (mem_cnt == 0);
         end else begin
            rv = ($urandom_range(0, 19) == 0);      // stray response while idle
         end
         rst = 1'b0;
         stall_f = sf; stall_d = sd; flush_d = fl; pc_src_e = ps;
         pc_target_e = tgt; imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
         #1;
         e_req = !sf && !ps && (skidq.size() == 0) && (!m_out || rv);
         check("rnd_req", {31'd0, imem_req}, {31'd0, e_req});
         check("rnd_addr", imem_addr, m_pc);
         fire = e_req && g;
         live = m_out && rv && !m_wrong && !ps && !fl;

         if (ps || fl) begin
            m_valid = 0; m_instr = NOP; skidq.delete();
         end else if (!sd) begin
            if (skidq.size() != 0) begin
               pkt = skidq.pop_front();
               m_valid = 1; m_instr = pkt.instr; m_pcd = pkt.pc;
               if (live) skidq.push_back('{instr: rd, pc: m_opc});
            end else if (live) begin
               m_valid = 1; m_instr = rd; m_pcd = m_opc;
            end else begin
               m_valid = 0; m_instr = NOP;
            end
         end else if (live) begin
            skidq.push_back('{instr: rd, pc: m_opc});
         end

         if (m_out && rv) begin
            m_out = 0; m_wrong = 0;
         end else if (m_out && ps) begin
            m_wrong = 1;
         end
         if (fire) begin
            m_out = 1; m_wrong = 0; m_opc = m_pc;
            mem_cnt = $urandom_range(1, 3);
         end
         if (ps) m_pc = tgt;
         else if (fire) m_pc = m_pc + 32'd4;

         tick();
         check("rnd_pc_f", pc_f, m_pc);
         check("rnd_valid", {31'd0, valid_d}, {31'd0, m_valid});
         check("rnd_instr", instr_d, m_instr);
         check("rnd_pc_d", pc_d, m_pcd);
         check("rnd_pc4", pc_plus4_d, m_pcd + 32'd4);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
